// File: rtl/colour_window_filter_if.sv
// Pixel stream, config and count bus for colour_window_filter.
// master drives pixels/config; slave (the filter) returns filtered pixels and counts.
interface colour_window_filter_if #(
    parameter int DATA_W  = 8,
    parameter int NUM_WIN = 4,
    parameter int CNT_W   = 20
);
    localparam int SEL_W  = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
    localparam int ADDR_W = 3 + SEL_W;

    logic [DATA_W-1:0]  iRed;
    logic [DATA_W-1:0]  iGreen;
    logic [DATA_W-1:0]  iBlue;
    logic               iValid;
    logic               iVS;
    logic [1:0]         iMode;
    logic               iCfg_we;
    logic [ADDR_W-1:0]  iCfg_addr;
    logic [DATA_W-1:0]  iCfg_data;
    logic [SEL_W-1:0]   iCnt_sel;

    logic [DATA_W-1:0]  oRed;
    logic [DATA_W-1:0]  oGreen;
    logic [DATA_W-1:0]  oBlue;
    logic               oValid;
    logic [NUM_WIN-1:0] oMatch;
    logic [CNT_W-1:0]   oCount;
    logic               oFrame_done;

    modport master (
        output iRed, iGreen, iBlue, iValid, iVS, iMode,
               iCfg_we, iCfg_addr, iCfg_data, iCnt_sel,
        input  oRed, oGreen, oBlue, oValid, oMatch, oCount, oFrame_done
    );

    modport slave (
        input  iRed, iGreen, iBlue, iValid, iVS, iMode,
               iCfg_we, iCfg_addr, iCfg_data, iCnt_sel,
        output oRed, oGreen, oBlue, oValid, oMatch, oCount, oFrame_done
    );
endinterface

// File: rtl/colour_window_filter.sv
// RGB box-window classifier/filter with per-window frame match counters; latency 2 cycles.
// No backpressure: bubbles flow through and output data holds; thresholds swap in at frame start.
module colour_window_filter #(
    parameter int              DATA_W  = 8,
    parameter int              NUM_WIN = 4,
    parameter int              CNT_W   = 20,
    parameter logic [DATA_W-1:0] HL_R  = 8'hFF,
    parameter logic [DATA_W-1:0] HL_G  = 8'h00,
    parameter logic [DATA_W-1:0] HL_B  = 8'hFF
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    colour_window_filter_if.slave  bus
);
    localparam int SEL_W  = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
    localparam int ADDR_W = 3 + SEL_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [DATA_W-1:0] r_min;
        logic [DATA_W-1:0] r_max;
        logic [DATA_W-1:0] g_min;
        logic [DATA_W-1:0] g_max;
        logic [DATA_W-1:0] b_min;
        logic [DATA_W-1:0] b_max;
        logic              en;
    } win_cfg_t;

    // Full-range but disabled: nothing matches until software enables a window.
    function automatic win_cfg_t cfg_reset();
        win_cfg_t c;
        c       = '0;
        c.r_max = '1;
        c.g_max = '1;
        c.b_max = '1;
        return c;
    endfunction

    function automatic logic in_range(input logic [DATA_W-1:0] c,
                                      input logic [DATA_W-1:0] lo,
                                      input logic [DATA_W-1:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

    win_cfg_t shadow_cfg [NUM_WIN];
    win_cfg_t active_cfg [NUM_WIN];

    logic              vs_d;
    logic              frame_start;
    logic [2:0]        cfg_field;
    logic [SEL_W-1:0]  cfg_win;

    assign frame_start = bus.iVS & ~vs_d;
    assign cfg_field   = bus.iCfg_addr[2:0];
    assign cfg_win     = bus.iCfg_addr[ADDR_W-1:3];

    // Nonblocking copy means an edge-cycle write lands in shadow only.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            vs_d <= 1'b0;
            for (int w = 0; w < NUM_WIN; w++) begin
                shadow_cfg[w] <= cfg_reset();
                active_cfg[w] <= cfg_reset();
            end
        end else begin
            vs_d <= bus.iVS;
            for (int w = 0; w < NUM_WIN; w++) begin
                if (frame_start)
                    active_cfg[w] <= shadow_cfg[w];
                if (bus.iCfg_we && (cfg_win == SEL_W'(w))) begin
                    case (cfg_field)
                        3'd0:    shadow_cfg[w].r_min <= bus.iCfg_data;
                        3'd1:    shadow_cfg[w].r_max <= bus.iCfg_data;
                        3'd2:    shadow_cfg[w].g_min <= bus.iCfg_data;
                        3'd3:    shadow_cfg[w].g_max <= bus.iCfg_data;
                        3'd4:    shadow_cfg[w].b_min <= bus.iCfg_data;
                        3'd5:    shadow_cfg[w].b_max <= bus.iCfg_data;
                        3'd6:    shadow_cfg[w].en    <= bus.iCfg_data[0];
                        default: ;
                    endcase
                end
            end
        end
    end

    logic [NUM_WIN-1:0] pix_match;

    always_comb begin
        pix_match = '0;
        for (int w = 0; w < NUM_WIN; w++) begin
            pix_match[w] = active_cfg[w].en
                         && in_range(bus.iRed,   active_cfg[w].r_min, active_cfg[w].r_max)
                         && in_range(bus.iGreen, active_cfg[w].g_min, active_cfg[w].g_max)
                         && in_range(bus.iBlue,  active_cfg[w].b_min, active_cfg[w].b_max);
        end
    end

    logic               s1_vld;
    logic [DATA_W-1:0]  s1_r;
    logic [DATA_W-1:0]  s1_g;
    logic [DATA_W-1:0]  s1_b;
    logic [NUM_WIN-1:0] s1_match;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            s1_vld   <= 1'b0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
            s1_match <= '0;
        end else begin
            s1_vld <= bus.iValid;
            if (bus.iValid) begin
                s1_r     <= bus.iRed;
                s1_g     <= bus.iGreen;
                s1_b     <= bus.iBlue;
                s1_match <= pix_match;
            end
        end
    end

    logic              s1_hit;
    logic [DATA_W-1:0] mode_r;
    logic [DATA_W-1:0] mode_g;
    logic [DATA_W-1:0] mode_b;

    assign s1_hit = |s1_match;

    always_comb begin
        mode_r = s1_r;
        mode_g = s1_g;
        mode_b = s1_b;
        case (bus.iMode)
            2'd1: if (!s1_hit) begin
                mode_r = '0;
                mode_g = '0;
                mode_b = '0;
            end
            2'd2: if (s1_hit) begin
                mode_r = HL_R;
                mode_g = HL_G;
                mode_b = HL_B;
            end
            2'd3: begin
                mode_r = s1_hit ? '1 : '0;
                mode_g = s1_hit ? '1 : '0;
                mode_b = s1_hit ? '1 : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bus.oValid <= 1'b0;
            bus.oRed   <= '0;
            bus.oGreen <= '0;
            bus.oBlue  <= '0;
            bus.oMatch <= '0;
        end else begin
            bus.oValid <= s1_vld;
            if (s1_vld) begin
                bus.oRed   <= mode_r;
                bus.oGreen <= mode_g;
                bus.oBlue  <= mode_b;
                bus.oMatch <= s1_match;
            end
        end
    end

    logic [CNT_W-1:0] run_cnt    [NUM_WIN];
    logic [CNT_W-1:0] latched_cnt[NUM_WIN];
    logic [CNT_W-1:0] cnt_next   [NUM_WIN];

    // cnt_next already folds in the S1 pixel, so the edge latch never drops it.
    always_comb begin
        for (int w = 0; w < NUM_WIN; w++) begin
            cnt_next[w] = run_cnt[w];
            if (s1_vld && s1_match[w] && (run_cnt[w] != CNT_MAX))
                cnt_next[w] = run_cnt[w] + 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bus.oFrame_done <= 1'b0;
            for (int w = 0; w < NUM_WIN; w++) begin
                run_cnt[w]     <= '0;
                latched_cnt[w] <= '0;
            end
        end else begin
            bus.oFrame_done <= frame_start;
            for (int w = 0; w < NUM_WIN; w++) begin
                if (frame_start) begin
                    latched_cnt[w] <= cnt_next[w];
                    run_cnt[w]     <= '0;
                end else begin
                    run_cnt[w]     <= cnt_next[w];
                end
            end
        end
    end

    always_comb begin
        bus.oCount = '0;
        for (int w = 0; w < NUM_WIN; w++) begin
            if (bus.iCnt_sel == SEL_W'(w))
                bus.oCount = latched_cnt[w];
        end
    end
endmodule

// File: tb/tb_colour_window_filter.sv
// Scoreboard bench: two filters (wide and 4-bit counters) share one stimulus stream.
module tb_colour_window_filter;
    localparam int DW   = 8;
    localparam int NW   = 4;
    localparam int CW   = 20;
    localparam int CW_S = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    colour_window_filter_if #(.DATA_W(DW), .NUM_WIN(NW), .CNT_W(CW))   ifa ();
    colour_window_filter_if #(.DATA_W(DW), .NUM_WIN(NW), .CNT_W(CW_S)) ifb ();

    colour_window_filter #(.DATA_W(DW), .NUM_WIN(NW), .CNT_W(CW)) dut (
        .iCLK(clk), .iRST_N(rst_n), .bus(ifa.slave));
    colour_window_filter #(.DATA_W(DW), .NUM_WIN(NW), .CNT_W(CW_S)) dut_sat (
        .iCLK(clk), .iRST_N(rst_n), .bus(ifb.slave));

    assign ifb.iRed      = ifa.iRed;
    assign ifb.iGreen    = ifa.iGreen;
    assign ifb.iBlue     = ifa.iBlue;
    assign ifb.iValid    = ifa.iValid;
    assign ifb.iVS       = ifa.iVS;
    assign ifb.iMode     = ifa.iMode;
    assign ifb.iCfg_we   = ifa.iCfg_we;
    assign ifb.iCfg_addr = ifa.iCfg_addr;
    assign ifb.iCfg_data = ifa.iCfg_data;
    assign ifb.iCnt_sel  = ifa.iCnt_sel;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    typedef struct {
        int         cyc;
        logic [7:0] r, g, b;
        logic [3:0] m;
    } pix_t;

    pix_t pq[$];
    int   fq[$];

    // Reference state: field order Rmin,Rmax,Gmin,Gmax,Bmin,Bmax,enable.
    int sh_cfg [NW][7];
    int act_cfg[NW][7];
    int run_model[NW];
    int lat_model[NW];
    bit prev_vs;
    int cur_mode;

    function automatic void model_reset();
        for (int w = 0; w < NW; w++) begin
            for (int f = 0; f < 7; f++) begin
                sh_cfg[w][f]  = (f == 1 || f == 3 || f == 5) ? 255 : 0;
                act_cfg[w][f] = sh_cfg[w][f];
            end
            run_model[w] = 0;
            lat_model[w] = 0;
        end
        prev_vs = 1'b0;
    endfunction

    function automatic bit hit(input int w, input int r, input int g, input int b);
        return act_cfg[w][6] != 0
            && r >= act_cfg[w][0] && r <= act_cfg[w][1]
            && g >= act_cfg[w][2] && g <= act_cfg[w][3]
            && b >= act_cfg[w][4] && b <= act_cfg[w][5];
    endfunction

    function automatic longint sat(input int v, input int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic drive(input bit vs, input bit vld, input int r, input int g, input int b,
                         input bit we, input int addr, input int data, input int sel);
        logic [3:0] m;
        bit         any;
        pix_t       e;
        ifa.iVS       = vs;
        ifa.iValid    = vld;
        ifa.iRed      = 8'(r);
        ifa.iGreen    = 8'(g);
        ifa.iBlue     = 8'(b);
        ifa.iMode     = 2'(cur_mode);
        ifa.iCfg_we   = we;
        ifa.iCfg_addr = 5'(addr);
        ifa.iCfg_data = 8'(data);
        ifa.iCnt_sel  = 2'(sel);
        for (int w = 0; w < NW; w++) m[w] = hit(w, r, g, b);
        any = |m;
        if (vld) begin
            e.cyc = cyc + 2;
            e.m   = m;
            case (cur_mode)
                0:       begin e.r = 8'(r); e.g = 8'(g); e.b = 8'(b); end
                1:       begin e.r = any ? 8'(r) : 8'd0; e.g = any ? 8'(g) : 8'd0; e.b = any ? 8'(b) : 8'd0; end
                2:       begin e.r = any ? 8'hFF : 8'(r); e.g = any ? 8'h00 : 8'(g); e.b = any ? 8'hFF : 8'(b); end
                default: begin e.r = any ? 8'hFF : 8'd0; e.g = e.r; e.b = e.r; end
            endcase
            pq.push_back(e);
        end
        if (vs && !prev_vs) begin
            for (int w = 0; w < NW; w++) begin
                lat_model[w] = run_model[w];
                run_model[w] = 0;
            end
            act_cfg = sh_cfg;
            fq.push_back(cyc + 1);
        end
        prev_vs = vs;
        if (vld)
            for (int w = 0; w < NW; w++) if (m[w]) run_model[w]++;
        if (we && (addr & 7) != 7 && (addr >> 3) < NW)
            sh_cfg[addr >> 3][addr & 7] = ((addr & 7) == 6) ? (data & 1) : data;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pix(input int r, input int g, input int b);
        drive(0, 1, r, g, b, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int w, input int f, input int d);
        drive(0, 0, 0, 0, 0, 1, (w << 3) | f, d, 0);
    endtask

    task automatic vs_pulse();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_mode(input int m);
        idle(2);
        cur_mode = m;
    endtask

    task automatic prog_win0();
        cfg(0, 0, 200); cfg(0, 1, 255);
        cfg(0, 2, 0);   cfg(0, 3, 50);
        cfg(0, 4, 0);   cfg(0, 5, 50);
        cfg(0, 6, 1);
    endtask

    always @(negedge clk) begin
        bit   ev;
        bit   ef;
        pix_t e;
        if (rst_n) begin
            ev = (pq.size() > 0) && (pq[0].cyc == cyc);
            chk("valid", ifa.oValid, ev);
            chk("valid_sat", ifb.oValid, ev);
            if (ev) begin
                e = pq.pop_front();
                chk("red", ifa.oRed, e.r);
                chk("green", ifa.oGreen, e.g);
                chk("blue", ifa.oBlue, e.b);
                chk("match", ifa.oMatch, e.m);
                chk("red_sat", ifb.oRed, e.r);
                chk("match_sat", ifb.oMatch, e.m);
            end
            ef = (fq.size() > 0) && (fq[0] == cyc);
            chk("frame_done", ifa.oFrame_done, ef);
            chk("frame_done_sat", ifb.oFrame_done, ef);
            if (ef) begin
                void'(fq.pop_front());
                chk("count", ifa.oCount, sat(lat_model[ifa.iCnt_sel], CW));
                chk("count_sat", ifb.oCount, sat(lat_model[ifa.iCnt_sel], CW_S));
            end
        end
    end

    initial begin
        int lo, hi;
        ifa.iVS = 0; ifa.iValid = 0; ifa.iRed = 0; ifa.iGreen = 0; ifa.iBlue = 0;
        ifa.iMode = 0; ifa.iCfg_we = 0; ifa.iCfg_addr = 0; ifa.iCfg_data = 0; ifa.iCnt_sel = 0;
        model_reset();
        cur_mode = 0;
        #12;
        chk("rst_red", ifa.oRed, 0);
        chk("rst_green", ifa.oGreen, 0);
        chk("rst_blue", ifa.oBlue, 0);
        chk("rst_valid", ifa.oValid, 0);
        chk("rst_match", ifa.oMatch, 0);
        chk("rst_frame_done", ifa.oFrame_done, 0);
        chk("rst_count", ifa.oCount, 0);
        chk("rst_count_sat", ifb.oCount, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pass-through with gaps.
        for (int i = 0; i < 16; i++) begin
            pix($urandom_range(255), $urandom_range(255), $urandom_range(255));
            if ($urandom_range(1) == 1) idle(1);
        end
        idle(3);

        // Window 0 boundaries across all modes.
        prog_win0();
        vs_pulse();
        for (int k = 0; k < 4; k++) begin
            set_mode(3 - k);
            pix(220, 10, 10); pix(199, 10, 10); pix(200, 50, 50);
            pix(255, 0, 0);   pix(200, 51, 0);  pix(200, 0, 51);
        end

        // Mid-frame write, then write on the exact edge cycle.
        cfg(0, 0, 100);
        pix(150, 10, 10);
        vs_pulse();
        pix(150, 10, 10);
        drive(1, 1, 150, 10, 10, 1, 1, 120, 0);
        drive(0, 1, 150, 10, 10, 0, 0, 0, 0);
        pix(130, 10, 10);
        vs_pulse();
        pix(150, 10, 10); pix(110, 10, 10);

        // 100-pixel frame count, saturation, and restart from zero.
        prog_win0();
        vs_pulse();
        for (int i = 0; i < 100; i++) begin
            pix(200 + $urandom_range(55), $urandom_range(50), $urandom_range(50));
            if ($urandom_range(3) == 0) pix(10, 200, 200);
        end
        idle(2);
        vs_pulse();
        idle(3);
        vs_pulse();

        // Randomised phases.
        for (int ph = 0; ph < 5; ph++) begin
            set_mode($urandom_range(3));
            for (int w = 0; w < NW; w++) begin
                for (int c = 0; c < 3; c++) begin
                    lo = $urandom_range(127);
                    hi = lo + 64 + $urandom_range(127);
                    if (hi > 255) hi = 255;
                    cfg(w, 2 * c, lo);
                    cfg(w, 2 * c + 1, hi);
                end
                cfg(w, 6, $urandom_range(7));
            end
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(15) == 0)
                    drive(((i % 50) >= 47), ($urandom_range(3) != 0),
                          $urandom_range(255), $urandom_range(255), $urandom_range(255),
                          1, $urandom_range(31), $urandom_range(255), $urandom_range(3));
                else
                    drive(((i % 50) >= 47), ($urandom_range(3) != 0),
                          $urandom_range(255), $urandom_range(255), $urandom_range(255),
                          0, 0, 0, $urandom_range(3));
            end
        end

        // Reset with pixels in flight.
        idle(2);
        prog_win0();
        vs_pulse();
        set_mode(3);
        for (int i = 0; i < 5; i++) pix(220, 10, 10);
        idle(3);
        vs_pulse();
        pix(220, 10, 10); pix(220, 10, 10);
        rst_n = 1'b0;
        ifa.iValid = 0;
        ifa.iVS = 0;
        #1;
        chk("mrst_valid", ifa.oValid, 0);
        chk("mrst_red", ifa.oRed, 0);
        chk("mrst_match", ifa.oMatch, 0);
        chk("mrst_frame_done", ifa.oFrame_done, 0);
        chk("mrst_count", ifa.oCount, 0);
        chk("mrst_valid_sat", ifb.oValid, 0);
        pq.delete();
        fq.delete();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int s = 0; s < NW; s++) begin
            ifa.iCnt_sel = 2'(s);
            #1;
            chk("post_rst_count", ifa.oCount, 0);
        end
        idle(4);
        pix(220, 10, 10); pix(220, 10, 10); pix(5, 5, 5);
        idle(2);
        vs_pulse();
        idle(4);

        chk("drain_pixels", pq.size(), 0);
        chk("drain_frames", fq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/colour_window_filter.md
Name: colour_window_filter

Overview:
- Streaming RGB pixel filter that sits between the D8M RGB source and the VGA controller input, in place of the processor-driven colour pass-through.
- Compares each pixel against NUM_WIN programmable RGB box windows and applies one of four output modes.
- Counts matching pixels per window per frame.
- Threshold writes are double-buffered and take effect only at frame start, so the frame being displayed never tears.

Parameters:
- DATA_W, 8: bits per colour channel.
- NUM_WIN, 4: number of colour windows (1..8).
- CNT_W, 20: width of the per-window match counters.
- HL_R / HL_G / HL_B, 8'hFF / 8'h00 / 8'hFF: highlight colour for mode 2.

Ports:
- iCLK  in  1  pixel clock
- iRST_N  in  1  asynchronous active-low reset
- iRed / iGreen / iBlue  in  DATA_W each  input pixel
- iValid  in  1  input pixel valid
- iVS  in  1  vertical sync, active-high; rising edge = frame start
- iMode  in  2  0 pass, 1 mask, 2 highlight, 3 binary
- iCfg_we  in  1  config write strobe
- iCfg_addr  in  3+$clog2(NUM_WIN)  {window, field}
- iCfg_data  in  DATA_W  config write data
- iCnt_sel  in  $clog2(NUM_WIN)  selects which window's count appears on oCount
- oRed / oGreen / oBlue  out  DATA_W each  filtered pixel
- oValid  out  1  output valid
- oMatch  out  NUM_WIN  per-window match flags, aligned with output pixel
- oCount  out  CNT_W  latched previous-frame count of the selected window
- oFrame_done  out  1  one-cycle pulse when counts are latched

Behaviour:
- Clock and reset: single clock domain iCLK; iRST_N is asynchronous and active-low.
- Config fields per window:
  - 0 Rmin, 1 Rmax, 2 Gmin, 3 Gmax, 4 Bmin, 5 Bmax, 6 enable (iCfg_data[0]).
  - Field 7 and window index >= NUM_WIN: write ignored.
  - Writes go to the shadow set on the iCfg_we cycle.
- Frame-start edge: vs_d registers iVS; edge = iVS & ~vs_d.
  - On the edge cycle the shadow set is copied to the active set.
  - The pixel sampled on the edge cycle is still compared against the old active set.
- Window match: every channel satisfies min <= c <= max (unsigned, inclusive), AND the window is enabled.
  - min > max never matches.
  - match_any = OR over all windows.
- Pipeline, fixed latency 2 cycles from iValid to oValid:
  - S1 registers RGB, valid and the per-window match vector.
  - S2 applies the mode and registers the outputs.
  - No backpressure. When iValid = 0 the bubble propagates and output data holds its last value.
- Modes, sampled in S2:
  - 0: RGB unchanged.
  - 1: non-matching pixels output 0.
  - 2: matching pixels output HL_R/HL_G/HL_B; others unchanged.
  - 3: matching pixels all-ones, others 0.
- Counters: running cnt[w] increments when S1 valid & S1 match[w]; saturates at 2^CNT_W-1.
  - On the edge cycle: latched[w] <= cnt[w] + inc[w] (saturated), and cnt[w] <= 0.
  - oFrame_done pulses on the cycle after the edge.
  - oCount = latched[iCnt_sel], combinational mux. An out-of-range iCnt_sel gives 0.
- Simultaneous cfg write and edge: the copy uses the shadow value from before the write. The write lands in shadow only and becomes active at the next edge.
- Reset values:
  - All outputs 0, oFrame_done 0, vs_d 0.
  - Counters and latched counts 0.
  - Shadow and active sets: min 0, max all-ones, enable 0, so nothing matches after reset.
- Reset mid-frame: pipeline contents and counts are discarded; no oFrame_done is generated.

Test Plan:
- Reset, mode 0, stream 16 valid pixels with iValid gaps -> each output equals its input exactly 2 cycles later; oValid pattern is a 2-cycle-delayed copy; oMatch = 0.
- Program window 0 to R 200..255, G 0..50, B 0..50, enable=1, then pulse iVS -> pixel (220,10,10) gives oMatch[0]=1; pixel (199,10,10) gives 0. Mode 3 outputs (FF,FF,FF) and (0,0,0); mode 2 outputs (FF,00,FF) for the match.
- Write new thresholds mid-frame -> matching behaviour is unchanged until the next iVS rising edge, then switches. A write on the exact edge cycle is not applied until the following edge.
- Frame with 100 matching valid pixels for window 0, then iVS edge -> oFrame_done pulses once; oCount (iCnt_sel=0) = 100; the next frame counts from 0.
- CNT_W=4, stream 20 matching pixels -> oCount saturates at 15.
- Assert iRST_N low mid-frame with pixels in flight -> outputs 0 immediately; after release oValid stays 0 until new input; latched counts are 0 and windows are disabled.
